// File: rtl/sdpram_pkg.sv
// Shared constants and types for the simple-dual-port-RAM FIFO controller.
// The default geometry is the same one that sdpram_if and simple_dual_port_ram use.
package sdpram_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ADDR_WIDTH = 4;
  localparam int DEF_MEM_DEPTH  = 16;

  typedef enum logic {
    EMPTY = 1'b0,
    VALID = 1'b1
  } out_state_e;

  // The occupancy count has to reach MEM_DEPTH+1 (a full RAM plus the presented word).
  function automatic int cnt_width(input int addr_w);
    return addr_w + 2;
  endfunction

endpackage

// File: rtl/sdpram_fifo_ptr.sv
// Wrapping RAM address pointer. It advances by one on inc and wraps modulo 2**W.
module sdpram_fifo_ptr #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] ptr
);

  logic [W-1:0] ptr_d, ptr_q;

  always_comb begin
    // NOTE: assign the default before the conditional so that no path leaves ptr_d unassigned (that would infer a latch).
    ptr_d = ptr_q;
    if (inc) ptr_d = ptr_q + W'(1);
  end

  // NOTE: use non-blocking assignments only in clocked blocks, so every flop samples its pre-edge value.
  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/sdpram_fifo_ctrl.sv
// FIFO controller placed in front of simple_dual_port_ram: it owns the pointers, the count and the output stage.
// Optional: define SDPRAM_FIFO_PEAK_EN to add the peak_count high-water-mark output.
module sdpram_fifo_ctrl
  import sdpram_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int MEM_DEPTH  = DEF_MEM_DEPTH
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            s_valid,
  input  logic [DATA_WIDTH-1:0]           s_data,
  output logic                            s_ready,
  output logic                            m_valid,
  output logic [DATA_WIDTH-1:0]           m_data,
  input  logic                            m_ready,
  output logic [cnt_width(ADDR_WIDTH)-1:0] count,
  output logic                            ram_wena,
  output logic [ADDR_WIDTH-1:0]           ram_addra,
  output logic [DATA_WIDTH-1:0]           ram_dina,
  output logic                            ram_renb,
  output logic [ADDR_WIDTH-1:0]           ram_addrb,
`ifdef SDPRAM_FIFO_PEAK_EN
  output logic [cnt_width(ADDR_WIDTH)-1:0] peak_count,
`endif
  input  logic [DATA_WIDTH-1:0]           ram_doutb
);

  localparam int CW = cnt_width(ADDR_WIDTH);
  localparam logic [ADDR_WIDTH:0] FULL_CNT = (ADDR_WIDTH+1)'(MEM_DEPTH);

  if (MEM_DEPTH != 2**ADDR_WIDTH) begin : g_depth_check
    $fatal(1, "sdpram_fifo_ctrl: MEM_DEPTH must equal 2**ADDR_WIDTH");
  end

  logic                 wr_go, rd_go;
  logic [ADDR_WIDTH:0]  mem_cnt_d, mem_cnt_q;
  out_state_e           state_d, state_q;

  assign s_ready = (mem_cnt_q != FULL_CNT);
  assign wr_go   = s_valid & s_ready;
  assign rd_go   = (mem_cnt_q != '0) & ((state_q == EMPTY) | m_ready);

  sdpram_fifo_ptr #(.W(ADDR_WIDTH)) u_wr_ptr (
    .clk(clk), .rst(rst), .inc(wr_go), .ptr(ram_addra)
  );

  sdpram_fifo_ptr #(.W(ADDR_WIDTH)) u_rd_ptr (
    .clk(clk), .rst(rst), .inc(rd_go), .ptr(ram_addrb)
  );

  assign ram_wena = wr_go;
  assign ram_dina = s_data;
  assign ram_renb = rd_go;

  // The RAM's registered read port serves as the output register: doutb holds while renb is low.
  assign m_data  = ram_doutb;
  assign m_valid = (state_q == VALID);
  assign count   = CW'(mem_cnt_q) + CW'(m_valid);

  always_comb begin
    mem_cnt_d = mem_cnt_q;
    unique case ({wr_go, rd_go})
      2'b10:   mem_cnt_d = mem_cnt_q + (ADDR_WIDTH+1)'(1);
      2'b01:   mem_cnt_d = mem_cnt_q - (ADDR_WIDTH+1)'(1);
      default: mem_cnt_d = mem_cnt_q;
    endcase

    state_d = state_q;
    unique case (state_q)
      EMPTY:   if (rd_go) state_d = VALID;
      VALID:   if (m_ready && !rd_go) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  // NOTE: only the control state is reset; the RAM array keeps stale words, which the cleared pointers make unreachable.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_cnt_q <= '0;
      state_q   <= EMPTY;
    end else begin
      mem_cnt_q <= mem_cnt_d;
      state_q   <= state_d;
    end
  end

`ifdef SDPRAM_FIFO_PEAK_EN
  logic [CW-1:0] peak_d, peak_q;

  always_comb begin
    peak_d = peak_q;
    if (count > peak_q) peak_d = count;
  end

  always_ff @(posedge clk) begin
    if (rst) peak_q <= '0;
    else     peak_q <= peak_d;
  end

  assign peak_count = peak_q;
`endif

endmodule

// File: tb/tb_sdpram_fifo_ctrl.sv
// Self-checking bench for sdpram_fifo_ctrl, with a behavioural RAM and a queue-based reference model.
// It checks a directed vector table, hand-written corner-case sequences and randomized traffic.
module tb_sdpram_fifo_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       s_valid = 1'b0;
  logic [7:0] s_data = '0;
  logic       s_ready;
  logic       m_valid;
  logic [7:0] m_data;
  logic       m_ready = 1'b0;
  logic [5:0] count;
  logic       ram_wena;
  logic [3:0] ram_addra;
  logic [7:0] ram_dina;
  logic       ram_renb;
  logic [3:0] ram_addrb;
  logic [7:0] ram_doutb;
`ifdef SDPRAM_FIFO_PEAK_EN
  logic [5:0] peak_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  sdpram_fifo_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .MEM_DEPTH(16)) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
    .count(count),
    .ram_wena(ram_wena), .ram_addra(ram_addra), .ram_dina(ram_dina),
    .ram_renb(ram_renb), .ram_addrb(ram_addrb),
`ifdef SDPRAM_FIFO_PEAK_EN
    .peak_count(peak_count),
`endif
    .ram_doutb(ram_doutb)
  );

  // Behavioural simple_dual_port_ram: 1-cycle registered read; doutb holds while renb is low.
  logic [7:0] mem [16];
  always @(posedge clk) begin
    if (ram_wena) mem[ram_addra] <= ram_dina;
    if (ram_renb) ram_doutb <= mem[ram_addrb];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: the words held in the RAM (in order), plus the word currently presented.
  logic [7:0] mq[$];
  bit         pv;
  logic [7:0] pd;
  int         wr_total, rd_total;

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; s_valid = 1'b0; m_ready = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    mq.delete(); pv = 0; pd = '0; wr_total = 0; rd_total = 0;
  endtask

  // Runs one clock cycle: drive inputs, compare the DUT with the model, then advance the model.
  task automatic step(input logic sv, input logic [7:0] sd, input logic mr);
    bit exp_rdy, wr, rd;
    @(negedge clk);
    s_valid = sv; s_data = sd; m_ready = mr;
    #1;
    exp_rdy = (mq.size() != 16);
    wr      = sv && exp_rdy;
    rd      = (mq.size() != 0) && (!pv || mr);
    check("s_ready", s_ready, exp_rdy);
    check("m_valid", m_valid, pv);
    if (pv) check("m_data", m_data, pd);
    check("count", count, mq.size() + int'(pv));
    check("ram_wena", ram_wena, wr);
    if (wr) begin
      check("ram_addra", ram_addra, wr_total % 16);
      check("ram_dina", ram_dina, sd);
    end
    check("ram_renb", ram_renb, rd);
    if (rd) check("ram_addrb", ram_addrb, rd_total % 16);
    if (rd) begin
      pd = mq.pop_front(); pv = 1; rd_total++;
    end else if (pv && mr) begin
      pv = 0;
    end
    if (wr) begin
      mq.push_back(sd); wr_total++;
    end
    @(posedge clk);
  endtask

  typedef struct {
    logic       sv;
    logic [7:0] sd;
    logic       mr;
    logic       e_rdy;
    logic       e_mv;
    logic [7:0] e_md;
    logic [5:0] e_cnt;
  } vec_t;

  vec_t vecs[8];

  initial begin
    // Write 0x11, 0x22, 0x33 while the consumer stalls, then drain.
    vecs[0] = '{1'b1, 8'h11, 1'b0, 1'b1, 1'b0, 8'h00, 6'd0};
    vecs[1] = '{1'b1, 8'h22, 1'b0, 1'b1, 1'b0, 8'h00, 6'd1};
    vecs[2] = '{1'b1, 8'h33, 1'b0, 1'b1, 1'b1, 8'h11, 6'd2};
    vecs[3] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h11, 6'd3};
    vecs[4] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h11, 6'd3};
    vecs[5] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h22, 6'd2};
    vecs[6] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h33, 6'd1};
    vecs[7] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 6'd0};

    do_reset();
    #1;
    check("rst_s_ready", s_ready, 1'b1);
    check("rst_m_valid", m_valid, 1'b0);
    check("rst_count", count, 6'd0);
    check("rst_wena", ram_wena, 1'b0);
    check("rst_renb", ram_renb, 1'b0);

    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      s_valid = vecs[i].sv; s_data = vecs[i].sd; m_ready = vecs[i].mr;
      #1;
      check($sformatf("vec%0d_s_ready", i), s_ready, vecs[i].e_rdy);
      check($sformatf("vec%0d_m_valid", i), m_valid, vecs[i].e_mv);
      if (vecs[i].e_mv) check($sformatf("vec%0d_m_data", i), m_data, vecs[i].e_md);
      check($sformatf("vec%0d_count", i), count, vecs[i].e_cnt);
      @(posedge clk);
    end

    // Fill to full with the consumer stalled: 17 words are accepted and the 18th is refused.
    do_reset();
    for (int i = 0; i < 17; i++) step(1'b1, 8'(i + 8'h40), 1'b0);
    @(negedge clk);
    s_valid = 1'b1; s_data = 8'hEE; m_ready = 1'b0;
    #1;
    check("full_count", count, 6'd17);
    check("full_s_ready", s_ready, 1'b0);
    check("full_wena", ram_wena, 1'b0);
    @(posedge clk);
    step(1'b1, 8'hEF, 1'b0);
    // Drain while writing: the slot freed in this cycle is not offered until the next one.
    step(1'b1, 8'hF0, 1'b1);
    step(1'b1, 8'hF1, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b0, 8'h00, 1'b1);

    // Streaming at one word per cycle through several pointer wraps.
    do_reset();
    for (int c = 0; c < 100; c++) begin
      #1;
      if (c >= 2) begin
        check("stream_m_valid", m_valid, 1'b1);
        check("stream_m_data", m_data, 8'(c - 2));
      end
      step(1'b1, 8'(c), 1'b1);
    end
    for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1);

    // Accept and drain at the same time with an empty RAM: m_valid drops for one cycle.
    do_reset();
    step(1'b1, 8'h5A, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    step(1'b1, 8'h5B, 1'b1);
    #1 check("bubble_m_valid", m_valid, 1'b0);
    step(1'b0, 8'h00, 1'b1);
    #1 check("bubble_new_word", m_data, 8'h5B);
    step(1'b0, 8'h00, 1'b1);

    // Back-pressure: m_ready toggles every cycle while random data streams in.
    do_reset();
    for (int c = 0; c < 200; c++) step(1'b1, 8'($urandom), 1'(c & 1));
    for (int i = 0; i < 40; i++) step(1'b0, 8'h00, 1'b1);

    // Random traffic that wanders between empty and full.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      int bias;
      bias = (c / 300) % 2;
      step(1'($urandom_range(0, 3) != 0), 8'($urandom),
           1'($urandom_range(0, 3) < (bias ? 1 : 3)));
    end

    // Reset in mid-operation discards the contents; the next word goes through cleanly.
    do_reset();
    for (int i = 0; i < 9; i++) step(1'b1, 8'(i), 1'b0);
    #1 check("pre_rst_count", count, 6'd9);
    do_reset();
    #1;
    check("mid_rst_count", count, 6'd0);
    check("mid_rst_m_valid", m_valid, 1'b0);
    check("mid_rst_s_ready", s_ready, 1'b1);
    step(1'b1, 8'hA5, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    #1;
    check("after_rst_m_valid", m_valid, 1'b1);
    check("after_rst_m_data", m_data, 8'hA5);
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b0);

`ifdef SDPRAM_FIFO_PEAK_EN
    // High-water mark: fill to 12, drain to 0, then clear with reset.
    do_reset();
    #1 check("peak_rst", peak_count, 6'd0);
    for (int i = 0; i < 12; i++) step(1'b1, 8'(i), 1'b0);
    for (int i = 0; i < 16; i++) step(1'b0, 8'h00, 1'b1);
    #1;
    check("peak_drained_count", count, 6'd0);
    check("peak_value", peak_count, 6'd12);
    do_reset();
    #1 check("peak_cleared", peak_count, 6'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
